// File: rtl/prbs30_checker.sv
// prbs30_checker
// Receive-side checker for the 30-bit Fibonacci LFSR stream (taps 29, 5, 3, 0,
// left shift, newest bit enters at bit 0). It consumes one bit per in_valid
// strobe and goes through three phases:
//   - HUNT: fills the shift register with 30 received bits.
//   - SYNC: counts consecutive correct predictions before declaring lock.
//   - LOCKED: regenerates the sequence locally (flywheel), flags each
//     mismatching bit once, and drops lock when too many errors land in one
//     window.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_bit     in   received serial bit
//   in_valid   in   in_bit is consumed on this edge
//   clear_cnt  in   synchronous clear of err_count
//   locked     out  high while in LOCKED (registered)
//   err_pulse  out  one-cycle pulse per mismatching bit while LOCKED
//   err_count  out  saturating count of errors seen while LOCKED

module prbs30_checker #(
  parameter int LOCK_COUNT  = 32,
  parameter int LOSS_ERRORS = 4,
  parameter int LOSS_WINDOW = 64,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(LOSS_WINDOW + 1);
  localparam int EW = $clog2(LOSS_ERRORS + 1);

  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_COUNT);
  localparam logic [WW-1:0] WIN_V  = WW'(LOSS_WINDOW);
  localparam logic [EW-1:0] LOSS_V = EW'(LOSS_ERRORS);

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_e;

  state_e                 state_q;
  logic [29:0]            shift_q;
  logic [4:0]             fill_q;
  logic [MW-1:0]          match_q;
  logic [WW-1:0]          window_q;
  logic [EW-1:0]          werr_q;
  logic [ERR_CNT_W-1:0]   errCount_q;
  logic [ERR_CNT_W-1:0]   errCount_d;
  logic                   locked_q;
  logic                   errPulse_q;

  logic                   pred;
  logic                   bitErr;
  logic [MW-1:0]          matchInc;
  logic [WW-1:0]          windowInc;
  logic [EW-1:0]          werrNext;

  // The prediction is the generator's next bit given that the shift register
  // holds the last 30 bits, with the newest bit at position 0.
  assign pred      = shift_q[29] ^ shift_q[5] ^ shift_q[3] ^ shift_q[0];
  assign bitErr    = in_valid && (state_q == LOCKED) && (in_bit != pred);
  assign matchInc  = match_q + MW'(1);
  assign windowInc = window_q + WW'(1);
  assign werrNext  = bitErr ? (werr_q + EW'(1)) : werr_q;

  // The error counter saturates at all-ones. A clear that coincides with an
  // error leaves that error counted, so the result is 1 rather than 0.
  always_comb begin
    errCount_d = errCount_q;
    if (clear_cnt) begin
      errCount_d = bitErr ? ERR_CNT_W'(1) : '0;
    end else if (bitErr && (errCount_q != '1)) begin
      errCount_d = errCount_q + ERR_CNT_W'(1);
    end
  end

  // Main state machine. Idle edges hold every counter and the shift register.
  // In SYNC the received bit is shifted in, so a wrong start point heals
  // itself. In LOCKED the prediction is shifted in, so a corrupted bit never
  // pollutes later predictions and is counted exactly once. When lock is
  // lost, the error count is checked before the window wrap, so a fourth
  // error on the last bit of a window still drops lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      shift_q    <= '0;
      fill_q     <= '0;
      match_q    <= '0;
      window_q   <= '0;
      werr_q     <= '0;
      errCount_q <= '0;
      locked_q   <= 1'b0;
      errPulse_q <= 1'b0;
    end else begin
      errPulse_q <= bitErr;
      errCount_q <= errCount_d;
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            shift_q <= {shift_q[28:0], in_bit};
            fill_q  <= fill_q + 5'd1;
            if (fill_q == 5'd29) begin
              state_q <= SYNC;
              match_q <= '0;
            end
          end
          SYNC: begin
            shift_q <= {shift_q[28:0], in_bit};
            if ((in_bit == pred) && (shift_q != '0)) begin
              match_q <= matchInc;
              if (matchInc == LOCK_V) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                window_q <= '0;
                werr_q   <= '0;
              end
            end else begin
              match_q <= '0;
            end
          end
          LOCKED: begin
            shift_q <= {shift_q[28:0], pred};
            if (werrNext == LOSS_V) begin
              state_q  <= HUNT;
              locked_q <= 1'b0;
              fill_q   <= '0;
              window_q <= windowInc;
              werr_q   <= werrNext;
            end else if (windowInc == WIN_V) begin
              window_q <= '0;
              werr_q   <= '0;
            end else begin
              window_q <= windowInc;
              werr_q   <= werrNext;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            fill_q   <= '0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = errPulse_q;
  assign err_count = errCount_q;

endmodule
